step_controller: RTL and testbench
==================================

# step_controller

Converts debounced push-button levels into CPU clock-enable control for the five-stage pipeline on the Spartan3E board. Sits directly downstream of the push-button debouncer and drives the pipeline's global stall/enable input. Supports single-step (one enable pulse per press), hold-to-auto-repeat stepping, and free-run, and counts issued enable cycles for the LED/LCD display.

## Interface
- HOLD_CYCLES, 25_000_000: cycles step must stay held after the first pulse before auto-repeat starts; must be ≥ 2.
- REPEAT_CYCLES, 5_000_000: period of auto-repeat pulses; must be ≥ 2.
- CNT_W, 16: width of step_count.
- clock  in  1  system clock, all logic on rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- step_btn  in  1  debounced step button level, synchronous to clock.
- run_btn  in  1  debounced run/pause toggle button level, synchronous to clock.
- cpu_enable  out  1  registered pipeline enable; high = pipeline advances this cycle.
- running  out  1  registered; high while in RUN.
- step_count  out  CNT_W  registered count of cycles in which cpu_enable was high.

## Operation
- Rise detection: step_q and run_q register previous levels. step_rise = step_btn & ~step_q; run_rise = run_btn & ~run_q.
- Timer: single down-counter shared by HOLD and REPEAT, width $clog2(max(HOLD_CYCLES, REPEAT_CYCLES)).
- FSM states are IDLE, HOLD, REPEAT and RUN:
  - IDLE: run_rise → RUN. Otherwise step_rise → pulse, load timer with HOLD_CYCLES-1, → HOLD.
  - HOLD: run_rise → RUN. Else step_btn low → IDLE. Else timer == 0 → pulse, load REPEAT_CYCLES-1, → REPEAT. Else decrement.
  - REPEAT: run_rise → RUN. Else step_btn low → IDLE. Else timer == 0 → pulse, reload REPEAT_CYCLES-1. Else decrement.
  - RUN: run_rise → IDLE. step_btn ignored entirely.
- "Pulse" means cpu_enable <= 1 for exactly one cycle. In RUN, cpu_enable <= 1 every cycle. Otherwise cpu_enable <= 0.
- On the edge leaving RUN, cpu_enable <= 0.
- Simultaneous step_rise and run_rise: run wins, and no step pulse is issued.
- step_count increments by 1 on every edge where cpu_enable is high. It wraps from 2^CNT_W-1 to 0 with no flag.
- running <= (next state == RUN).

## Timing
- Reset (async assert, sync to clock domain on release): state IDLE; cpu_enable 0; running 0; step_count 0; step_q, run_q, timer 0.
- A button held high through reset release does not produce a rise. It must go low and high again.
- Step latency: cpu_enable is high from edge k to edge k+1, where edge k is the first edge sampling step_btn high.
- Held step: pulses begin at edges k, k+HOLD_CYCLES, k+HOLD_CYCLES+REPEAT_CYCLES, and so on, each one cycle wide.
- Run latency: for a run_rise sampled at edge k, running and cpu_enable are high from edge k.
- Pause: for a run_rise sampled at edge k while in RUN, cpu_enable and running are low from edge k.
- Release during HOLD/REPEAT: the return to IDLE occurs on the first edge sampling step_btn low, with no pulse on that edge.
- Reset asserted mid-operation clears everything immediately, including step_count.

## Structure
- Shared package step_ctrl_pkg holds:
  - typedef enum logic [1:0] {IDLE=2'd0, HOLD=2'd1, REPEAT=2'd2, RUN=2'd3} step_state_t;
  - default HOLD/REPEAT constants for 50 MHz.
- Sub-module rise_detect (clock, reset_n, level → pulse), instantiated twice (step, run).
- The FSM, timer and counter stay in step_controller.

## Test plan
Benches use HOLD_CYCLES=8, REPEAT_CYCLES=3, CNT_W=4.
- Reset, then step_btn high for 1 cycle → exactly one cpu_enable cycle, one edge after sampling; step_count=1; running=0.
- step_btn held 20 cycles → pulses at offsets 0, 8, 11, 14, 17 relative to the first sampled-high edge; step_count=5; IDLE after release.
- run_btn press → cpu_enable high continuously. Second run_btn press after 10 cycles → cpu_enable low; step_count=10; running toggles 1→0.
- step_btn and run_btn rise on the same edge in IDLE → RUN entered, no extra step pulse counted, running=1.
- 16 single-step presses from reset → step_count wraps to 0. A 17th press → 1.
- reset_n asserted mid-REPEAT → all outputs 0 immediately. Button held through release → no pulse until re-pressed.

Source files
------------

// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the push-button step controller.
// Contents:
//   step_state_t       - controller FSM state encoding
//   HOLD_CYCLES_50MHZ  - default hold-before-repeat time (0.5 s at 50 MHz)
//   REPEAT_CYCLES_50MHZ- default auto-repeat period (0.1 s at 50 MHz)
//   timer_width()      - width of the shared hold/repeat down-counter
package step_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HOLD   = 2'd1,
    REPEAT = 2'd2,
    RUN    = 2'd3
  } step_state_t;

  localparam int unsigned HOLD_CYCLES_50MHZ   = 32'd25_000_000;
  localparam int unsigned REPEAT_CYCLES_50MHZ = 32'd5_000_000;

  // One timer serves both phases, so it must hold the larger reload value.
  function automatic int unsigned timer_width(input int unsigned hold_cycles,
                                              input int unsigned repeat_cycles);
    int unsigned widest;
    if (hold_cycles > repeat_cycles) begin
      widest = hold_cycles;
    end else begin
      widest = repeat_cycles;
    end
    return $clog2(widest);
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Rising-edge detector for a debounced, clock-synchronous button level.
// Ports:
//   clock   in  system clock
//   reset_n in  asynchronous active-low reset
//   level   in  button level
//   pulse   out one-cycle (combinational) high when level rises
// A level that is already high when reset releases is not treated as a
// press: the detector stays disarmed until it has seen the level low once.
module rise_detect (
  input  logic clock,
  input  logic reset_n,
  input  logic level,
  output logic pulse
);

  logic level_q_r;
  logic armed_r;

  // Previous-level register and post-reset arming flag.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      level_q_r <= 1'b0;
      armed_r   <= 1'b0;
    end else begin
      level_q_r <= level;
      armed_r   <= armed_r | ~level;
    end
  end

  assign pulse = level & ~level_q_r & armed_r;

endmodule

// File: rtl/step_controller.sv
// Converts debounced step/run button levels into the pipeline clock enable.
// Modes: single step (one pulse per press), hold-to-auto-repeat, free run.
// Ports:
//   clock      in  system clock
//   reset_n    in  asynchronous active-low reset
//   step_btn   in  debounced step button level
//   run_btn    in  debounced run/pause toggle level
//   cpu_enable out registered pipeline enable
//   running    out registered, high while in RUN
//   step_count out registered count of cycles with cpu_enable high (wraps)
module step_controller
  import step_ctrl_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES   = HOLD_CYCLES_50MHZ,
  parameter int unsigned REPEAT_CYCLES = REPEAT_CYCLES_50MHZ,
  parameter int unsigned CNT_W         = 16
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             step_btn,
  input  logic             run_btn,
  output logic             cpu_enable,
  output logic             running,
  output logic [CNT_W-1:0] step_count
);

  localparam int unsigned TW = timer_width(HOLD_CYCLES, REPEAT_CYCLES);
  localparam logic [TW-1:0] HOLD_LOAD   = TW'(HOLD_CYCLES - 32'd1);
  localparam logic [TW-1:0] REPEAT_LOAD = TW'(REPEAT_CYCLES - 32'd1);

  step_state_t      state_r;
  step_state_t      state_nx_s;
  logic [TW-1:0]    timer_r;
  logic [TW-1:0]    timer_nx_s;
  logic             pulse_s;
  logic             enable_nx_s;
  logic             cpu_enable_r;
  logic             running_r;
  logic [CNT_W-1:0] count_r;
  logic             step_rise_s;
  logic             run_rise_s;

  rise_detect u_step_rise (
    .clock   (clock),
    .reset_n (reset_n),
    .level   (step_btn),
    .pulse   (step_rise_s)
  );

  rise_detect u_run_rise (
    .clock   (clock),
    .reset_n (reset_n),
    .level   (run_btn),
    .pulse   (run_rise_s)
  );

  // Next-state, timer and enable decode. run_rise has priority everywhere,
  // which also suppresses a step pulse on a simultaneous press.
  always_comb begin
    state_nx_s = state_r;
    timer_nx_s = timer_r;
    pulse_s    = 1'b0;
    case (state_r)
      IDLE: begin
        if (run_rise_s) begin
          state_nx_s = RUN;
        end else if (step_rise_s) begin
          pulse_s    = 1'b1;
          timer_nx_s = HOLD_LOAD;
          state_nx_s = HOLD;
        end else begin
          state_nx_s = IDLE;
        end
      end
      HOLD: begin
        if (run_rise_s) begin
          state_nx_s = RUN;
        end else if (!step_btn) begin
          state_nx_s = IDLE;
        end else if (timer_r == {TW{1'b0}}) begin
          pulse_s    = 1'b1;
          timer_nx_s = REPEAT_LOAD;
          state_nx_s = REPEAT;
        end else begin
          timer_nx_s = timer_r - TW'(1);
        end
      end
      REPEAT: begin
        if (run_rise_s) begin
          state_nx_s = RUN;
        end else if (!step_btn) begin
          state_nx_s = IDLE;
        end else if (timer_r == {TW{1'b0}}) begin
          pulse_s    = 1'b1;
          timer_nx_s = REPEAT_LOAD;
        end else begin
          timer_nx_s = timer_r - TW'(1);
        end
      end
      RUN: begin
        if (run_rise_s) begin
          state_nx_s = IDLE;
        end else begin
          state_nx_s = RUN;
        end
      end
      default: begin
        state_nx_s = IDLE;
      end
    endcase
    enable_nx_s = pulse_s | (state_nx_s == RUN);
  end

  // State, timer and registered outputs; the counter tallies the enable
  // value that was presented to the pipeline in the cycle just ending.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_r      <= IDLE;
      timer_r      <= {TW{1'b0}};
      cpu_enable_r <= 1'b0;
      running_r    <= 1'b0;
      count_r      <= {CNT_W{1'b0}};
    end else begin
      state_r      <= state_nx_s;
      timer_r      <= timer_nx_s;
      cpu_enable_r <= enable_nx_s;
      running_r    <= (state_nx_s == RUN);
      count_r      <= count_r + CNT_W'(cpu_enable_r);
    end
  end

  assign cpu_enable = cpu_enable_r;
  assign running    = running_r;
  assign step_count = count_r;

endmodule

// File: tb/tb_step_controller.sv
module tb_step_controller;

  localparam int HOLD = 8;
  localparam int REP  = 3;
  localparam int CW   = 4;

  logic          clock   = 1'b0;
  logic          reset_n = 1'b0;
  logic          step_btn = 1'b0;
  logic          run_btn  = 1'b0;
  logic          cpu_enable;
  logic          running;
  logic [CW-1:0] step_count;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  int m_mode;   // 0 idle, 1 stepping (button held after a press), 2 run
  int m_t;      // edges since the press edge while stepping
  int m_en;
  int m_run;
  int m_cnt;
  bit m_ps, m_pr, m_as, m_ar;

  step_controller #(
    .HOLD_CYCLES   (HOLD),
    .REPEAT_CYCLES (REP),
    .CNT_W         (CW)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .step_btn   (step_btn),
    .run_btn    (run_btn),
    .cpu_enable (cpu_enable),
    .running    (running),
    .step_count (step_count)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d want %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = 0; m_t = 0; m_en = 0; m_run = 0; m_cnt = 0;
    m_ps = 1'b0; m_pr = 1'b0; m_as = 1'b0; m_ar = 1'b0;
  endtask

  task automatic model_edge(input bit s, input bit r);
    bit srise, rrise;
    m_cnt = (m_cnt + m_en) % (1 << CW);
    srise = s && !m_ps && m_as;
    rrise = r && !m_pr && m_ar;
    m_as  = m_as || !s;
    m_ar  = m_ar || !r;
    m_ps  = s;
    m_pr  = r;
    if (m_mode == 2) begin
      if (rrise) begin m_mode = 0; m_en = 0; end
      else m_en = 1;
    end else if (rrise) begin
      m_mode = 2; m_en = 1;
    end else if (m_mode == 1) begin
      if (!s) begin
        m_mode = 0; m_en = 0;
      end else begin
        m_t++;
        m_en = (m_t >= HOLD && ((m_t - HOLD) % REP) == 0) ? 1 : 0;
      end
    end else if (srise) begin
      m_mode = 1; m_t = 0; m_en = 1;
    end else begin
      m_en = 0;
    end
    m_run = (m_mode == 2) ? 1 : 0;
  endtask

  // every-cycle compare against the model
  initial begin
    bit s, r, rn;
    model_reset();
    forever begin
      @(posedge clock);
      s = step_btn; r = run_btn; rn = reset_n;
      if (!rn) model_reset();
      else model_edge(s, r);
      #1;
      if (reset_n == rn) begin
        chk("model_en", int'(cpu_enable), m_en);
        chk("model_running", int'(running), m_run);
        chk("model_count", int'(step_count), m_cnt);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0; step_btn = 1'b0; run_btn = 1'b0;
    cyc(2);
    reset_n = 1'b1;
    cyc(2);
  endtask

  initial begin
    int exp_en;
    bit rst_hold;
    cyc(2);
    chk("reset_en", int'(cpu_enable), 0);
    chk("reset_running", int'(running), 0);
    chk("reset_count", int'(step_count), 0);

    // single step
    do_reset();
    step_btn = 1'b1;
    @(negedge clock);
    chk("s1_pulse", int'(cpu_enable), 1);
    step_btn = 1'b0;
    @(negedge clock);
    chk("s1_gone", int'(cpu_enable), 0);
    cyc(2);
    chk("s1_count", int'(step_count), 1);
    chk("s1_running", int'(running), 0);

    // held step: pulses at offsets 0, 8, 11, 14, 17
    do_reset();
    step_btn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clock);
      exp_en = (i == 0 || i == 8 || i == 11 || i == 14 || i == 17) ? 1 : 0;
      chk($sformatf("hold_off%0d", i), int'(cpu_enable), exp_en);
      if (i == 19) step_btn = 1'b0;
    end
    cyc(3);
    chk("hold_count", int'(step_count), 5);
    chk("hold_idle_en", int'(cpu_enable), 0);

    // run for 10 cycles then pause
    do_reset();
    run_btn = 1'b1;
    @(negedge clock);
    chk("run_en", int'(cpu_enable), 1);
    chk("run_running", int'(running), 1);
    run_btn = 1'b0;
    cyc(9);
    run_btn = 1'b1;
    @(negedge clock);
    chk("pause_en", int'(cpu_enable), 0);
    chk("pause_running", int'(running), 0);
    run_btn = 1'b0;
    cyc(2);
    chk("run_count", int'(step_count), 10);

    // simultaneous step and run rise
    do_reset();
    step_btn = 1'b1; run_btn = 1'b1;
    @(negedge clock);
    chk("both_running", int'(running), 1);
    chk("both_en", int'(cpu_enable), 1);
    step_btn = 1'b0; run_btn = 1'b0;
    cyc(4);
    chk("both_count", int'(step_count), 4);
    run_btn = 1'b1;
    @(negedge clock);
    run_btn = 1'b0;
    cyc(2);

    // counter wrap
    do_reset();
    repeat (16) begin
      step_btn = 1'b1;
      @(negedge clock);
      step_btn = 1'b0;
      cyc(2);
    end
    chk("wrap_count", int'(step_count), 0);
    step_btn = 1'b1;
    @(negedge clock);
    step_btn = 1'b0;
    cyc(2);
    chk("wrap_count17", int'(step_count), 1);

    // reset in REPEAT, button held through release
    do_reset();
    step_btn = 1'b1;
    cyc(12);
    #2 reset_n = 1'b0;
    #1;
    chk("midrst_en", int'(cpu_enable), 0);
    chk("midrst_running", int'(running), 0);
    chk("midrst_count", int'(step_count), 0);
    cyc(2);
    reset_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      chk("held_no_pulse", int'(cpu_enable), 0);
    end
    step_btn = 1'b0;
    cyc(2);
    step_btn = 1'b1;
    @(negedge clock);
    chk("repress_pulse", int'(cpu_enable), 1);
    step_btn = 1'b0;
    cyc(2);

    // randomized phase
    do_reset();
    rst_hold = 1'b0;
    repeat (3000) begin
      @(negedge clock);
      if ($urandom_range(0, 11) == 0) step_btn = ~step_btn;
      if ($urandom_range(0, 39) == 0) run_btn = ~run_btn;
      if (rst_hold) begin
        reset_n = 1'b1; rst_hold = 1'b0;
      end else if ($urandom_range(0, 699) == 0) begin
        reset_n = 1'b0; rst_hold = 1'b1;
      end
    end
    reset_n = 1'b1;
    cyc(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
